// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller.
// Optional perf counters live behind HAZARD_PERF_EN in hazard_ctrl.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_STALL,
    REDIRECT
  } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-register bits for long-latency ops.
// Issue beats completion on the same register.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rd_a,
  input  logic [REG_AW-1:0] rd_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic              busy
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_nxt;

  always_comb begin
    sb_nxt = sb;
    if (clr_en)
      sb_nxt[clr_rd] = 1'b0;
    if (set_en && set_rd != '0)
      sb_nxt[set_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      sb <= '0;
    else
      sb <= sb_nxt;
  end

  assign pend_a = sb[rd_a];
  assign pend_b = sb[rd_b];
  assign busy   = |sb;

endmodule

// File: rtl/hazard_ctrl.sv
// Stateful hazard unit: forwarding, load-use, redirect, scoreboard.
// Define HAZARD_PERF_EN for stall/redirect perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW          = REG_AW_DEF,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLUSH_CYCLES    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memread_e,
  input  logic              redirect_e,
  input  logic              lop_issue_e,
  input  logic [REG_AW-1:0] lop_rd_e,
  input  logic              lop_done,
  input  logic [REG_AW-1:0] lop_done_rd,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_redirects
`endif
);

  localparam logic [1:0] SCNT0 = 2'(LOAD_USE_STALLS - 1);
  localparam logic [1:0] FCNT0 = 2'(FLUSH_CYCLES - 1);

  function automatic fwd_sel_t fwd(
    input logic [REG_AW-1:0] rs,
    input logic              we_m,
    input logic [REG_AW-1:0] dm,
    input logic              we_w,
    input logic [REG_AW-1:0] dw
  );
    if (we_m && dm != '0 && dm == rs)
      return FWD_MEM;
    if (we_w && dw != '0 && dw == rs)
      return FWD_WB;
    return FWD_RF;
  endfunction

  assign forward_a_e =
    fwd(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
  assign forward_b_e =
    fwd(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);

  logic pend_a;
  logic pend_b;

  hazard_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (lop_issue_e),
    .set_rd (lop_rd_e),
    .clr_en (lop_done),
    .clr_rd (lop_done_rd),
    .rd_a   (rs1_d),
    .rd_b   (rs2_d),
    .pend_a (pend_a),
    .pend_b (pend_b),
    .busy   (busy)
  );

  hz_state_t  state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       hit, sb_stall;
  logic       fsm_stall, fsm_bub;

  assign hit = memread_e && rd_e != '0 &&
               (rd_e == rs1_d || rd_e == rs2_d);
  assign sb_stall = (pend_a || pend_b) && !redirect_e;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fsm_stall = 1'b0;
    fsm_bub   = 1'b0;
    flush_d   = 1'b0;
    if (redirect_e) begin
      // a redirect kills whatever the stall was holding
      flush_d = 1'b1;
      fsm_bub = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = REDIRECT;
        cnt_nxt   = FCNT0;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            fsm_stall = 1'b1;
            fsm_bub   = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
              state_nxt = LOAD_STALL;
              cnt_nxt   = SCNT0;
            end
          end
        end
        LOAD_STALL: begin
          fsm_stall = 1'b1;
          fsm_bub   = 1'b1;
          cnt_nxt   = cnt - 2'd1;
          if (cnt == 2'd1)
            state_nxt = IDLE;
        end
        REDIRECT: begin
          flush_d = 1'b1;
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1)
            state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign stall_f = fsm_stall || sb_stall;
  assign stall_d = fsm_stall || sb_stall;
  assign flush_e = fsm_bub || sb_stall;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + 32'(stall_d);
      perf_redirects    <= perf_redirects + 32'(redirect_e);
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised, stateful successor to the combinational hazard detector for the 5-stage RV32I pipeline.
- Keeps the EX-stage forwarding selects and the load-use stall.
- Adds a multi-cycle load-use stall counter and a multi-cycle redirect flush for deeper fetch.
- Adds a register scoreboard for long-latency ops (e.g. multi-cycle memory or divider) that complete out of band.
- Sits beside the datapath and drives stall/flush for IF/ID/EX plus forwarding muxes in EX.

Parameters:
- REG_AW, 5, register index width; register file has 2**REG_AW entries and x0 is hard-wired zero.
- LOAD_USE_STALLS, 1, bubble cycles on a load-use hazard (legal 1..3).
- FLUSH_CYCLES, 1, cycles flush_d stays high after a redirect (legal 1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rs1_d, rs2_d  in  REG_AW  source registers of the ID instruction
- rs1_e, rs2_e  in  REG_AW  source registers of the EX instruction
- rd_e, rd_m, rd_w  in  REG_AW  destinations in EX, MEM, WB
- regwrite_m, regwrite_w  in  1  write enables in MEM, WB
- memread_e  in  1  EX instruction is a load
- redirect_e  in  1  taken branch / JAL / JALR resolved in EX
- lop_issue_e  in  1  long-latency op leaves EX this cycle
- lop_rd_e  in  REG_AW  destination of that op
- lop_done  in  1  long-latency op completes (result written this cycle)
- lop_done_rd  in  REG_AW  destination of the completing op
- forward_a_e, forward_b_e  out  2  00 register file, 01 WB result, 10 MEM ALU result
- stall_f, stall_d  out  1  hold PC and the IF/ID register
- flush_d  out  1  clear the IF/ID register
- flush_e  out  1  insert a bubble into the ID/EX register
- busy  out  1  scoreboard holds at least one pending register

Behaviour:
Reset:
- Synchronous on rst; overrides all other inputs in that cycle.
- After reset: state IDLE, counters 0, scoreboard all 0, every output 0.
- Asserting rst mid-stall or mid-flush aborts it at the next edge.

Forwarding (combinational):
- For each operand, select MEM (10) if regwrite_m, rd_m != 0 and rd_m == rs*_e.
- Otherwise select WB (01) if regwrite_w, rd_w != 0 and rd_w == rs*_e.
- Otherwise 00.

Load-use hazard:
- hit = memread_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d).
- Registers with index 0 never produce a hazard.

FSM states: IDLE, LOAD_STALL, REDIRECT.
- IDLE + redirect_e:
  - flush_d = 1 and flush_e = 1 this cycle.
  - If FLUSH_CYCLES > 1, go to REDIRECT with fcnt = FLUSH_CYCLES-1.
- IDLE + hit (no redirect):
  - stall_f = stall_d = flush_e = 1 this cycle.
  - If LOAD_USE_STALLS > 1, go to LOAD_STALL with scnt = LOAD_USE_STALLS-1.
- LOAD_STALL:
  - stall_f = stall_d = flush_e = 1.
  - scnt decrements each cycle; return to IDLE on the edge where scnt goes 1 -> 0.
- REDIRECT:
  - flush_d = 1 only.
  - fcnt decrements; return to IDLE when it reaches 0.
  - A new redirect_e reloads fcnt and also asserts flush_e.
- Priority: redirect_e beats any stall in the same cycle. A redirect during LOAD_STALL cancels the stall (stalled younger instructions are dead) and enters the REDIRECT path.
- With LOAD_USE_STALLS = 1 and FLUSH_CYCLES = 1 the outputs match the single-cycle detector exactly.

Scoreboard (one bit per register):
- On rst, all bits clear.
- Set: lop_issue_e & lop_rd_e != 0 sets bit lop_rd_e.
- Clear: lop_done clears bit lop_done_rd.
- Same register set and cleared in one cycle: set wins (a new op issued behind an old one).
- Scoreboard stall: sb[rs1_d] | sb[rs2_d] asserts stall_f, stall_d, flush_e.
  - Evaluated from registered bits, so release happens the cycle after lop_done.
  - Ignored in a cycle where redirect_e = 1.
- busy = OR of all bits.
- Bit 0 is never set.

Output combination:
- stall_f and stall_d are the OR of all stall sources; flush_e is the OR of the bubble and flush sources.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds 32-bit output ports perf_stall_cycles and perf_redirects.
  - perf_stall_cycles increments on every cycle with stall_d = 1.
  - perf_redirects increments on every cycle with redirect_e = 1.
  - Both wrap at 2**32, clear on rst, and add a bit-exact 1-cycle-later register view.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - hz_state_t enum: IDLE, LOAD_STALL, REDIRECT.
  - Default REG_AW.
- Sub-module hazard_scoreboard (parameter REG_AW) owns the scoreboard bit vector, set/clear priority, the two read ports and busy.

Test Plan:
1. rd_m = 5, regwrite_m = 1, rd_w = 5, regwrite_w = 1, rs1_e = 5 -> forward_a_e = 10; then rd_m = 0 -> forward_a_e = 01; rs1_e = 0 with any rd -> 00.
2. LOAD_USE_STALLS = 2, memread_e = 1, rd_e = 7, rs2_d = 7 -> stall_d and flush_e high for exactly 2 cycles, then 0; same stimulus with rd_e = 0 -> no stall.
3. FLUSH_CYCLES = 3, redirect_e pulsed 1 cycle -> flush_e high 1 cycle, flush_d high 3 cycles; redirect together with a load-use hit -> no stall, flush only.
4. Redirect in the 2nd cycle of a 3-cycle LOAD_STALL -> stall drops that cycle, flush_d / flush_e asserted, state REDIRECT.
5. lop_issue_e with rd = 9, then rs1_d = 9 -> stall until lop_done with rd = 9, released the following cycle, busy falls; simultaneous done(9) and issue(9) -> bit stays set.
6. rst asserted mid LOAD_STALL with scoreboard bits set -> next cycle all outputs 0, busy = 0; with HAZARD_PERF_EN, 4 stall cycles -> perf_stall_cycles = 4.
